// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote, per-frame status.
// Optional parity bit is built in when UART_RX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | start-bit window; a high vote is a false start
// DATA   | DATA_BITS data windows, LSB first
// PARITY | parity window (UART_RX_PARITY_EN only)
// STOP   | STOP_BITS stop windows; the final vote completes the frame
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] out_dat,
  output logic                 out_flag,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 brk_det,
  output logic                 rx_busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_S0   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_VOTE = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 samp0_q, samp0_d;
  logic                 samp1_q, samp1_d;
  logic                 stop_bad_q, stop_bad_d;
  logic [DATA_BITS-1:0] out_dat_q, out_dat_d;
  logic                 frame_err_q, frame_err_d;
  logic                 out_flag_q, out_flag_d;
  logic                 brk_q, brk_d;
  logic                 rxd_meta_q, rxd_s_q, rxd_d_q;
  logic [1:0]           settle_q;
  logic                 armed_q;
  logic                 vote, at_vote, at_end, last_stop, first_stop_zero;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_bit_q, par_bit_d;
  logic par_err_q, par_err_d;
  logic parity_err_q, parity_err_d;
`endif

  assign vote            = (samp0_q & samp1_q) | (samp0_q & rxd_s_q) | (samp1_q & rxd_s_q);
  assign at_vote         = (cnt_q == CNT_VOTE);
  assign at_end          = (cnt_q == CNT_END);
  assign last_stop       = (STOP_BITS == 1) || stop_idx_q;
  assign first_stop_zero = (STOP_BITS == 1) ? ~vote : stop_bad_q;

  // Line is armed only once a real high has come through the synchroniser after reset,
  // so a line already low at release is not taken as a start.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_d_q    <= 1'b1;
      settle_q   <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_d_q    <= rxd_s_q;
      settle_q   <= {settle_q[0], 1'b1};
      armed_q    <= armed_q | (settle_q[1] & rxd_s_q);
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      stop_idx_q  <= 1'b0;
      shift_q     <= '0;
      samp0_q     <= 1'b1;
      samp1_q     <= 1'b1;
      stop_bad_q  <= 1'b0;
      out_dat_q   <= '0;
      frame_err_q <= 1'b0;
      out_flag_q  <= 1'b0;
      brk_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      samp0_q     <= samp0_d;
      samp1_q     <= samp1_d;
      stop_bad_q  <= stop_bad_d;
      out_dat_q   <= out_dat_d;
      frame_err_q <= frame_err_d;
      out_flag_q  <= out_flag_d;
      brk_q       <= brk_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    samp0_d     = samp0_q;
    samp1_d     = samp1_q;
    stop_bad_d  = stop_bad_q;
    out_dat_d   = out_dat_q;
    frame_err_d = frame_err_q;
    out_flag_d  = 1'b0;
    brk_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    par_err_d    = par_err_q;
    parity_err_d = parity_err_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = at_end ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_S0) samp0_d = rxd_s_q;
      if (cnt_q == CNT_S1) samp1_d = rxd_s_q;
    end
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        idx_d      = '0;
        stop_idx_d = 1'b0;
        stop_bad_d = 1'b0;
        if (armed_q && rxd_d_q && !rxd_s_q) state_d = START;
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_vote) begin
          par_bit_d = vote;
          par_err_d = vote ^ (^shift_q) ^ PAR_ODD;
        end
        if (at_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (at_vote && last_stop) begin
          state_d     = IDLE;
          cnt_d       = '0;
          out_flag_d  = 1'b1;
          out_dat_d   = shift_q;
          frame_err_d = stop_bad_q | ~vote;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_err_q;
          brk_d        = (shift_q == '0) && first_stop_zero && !par_bit_q;
`else
          brk_d        = (shift_q == '0) && first_stop_zero;
`endif
        end else begin
          if (at_vote) stop_bad_d = stop_bad_q | ~vote;
          if (at_end) stop_idx_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_dat   = out_dat_q;
  assign out_flag  = out_flag_q;
  assign frame_err = frame_err_q;
  assign brk_det   = brk_q;
  assign rx_busy   = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: directed frames plus random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int C    = 16;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int PODD = 0;
  localparam int M    = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + DB + P + SB;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxd = 1'b1;
  logic [DB-1:0] out_dat;
  logic          out_flag, frame_err, parity_err, brk_det, rx_busy;

  uart_rx_param #(
    .CLKS_PER_BIT(C), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .rxd(rxd), .out_dat(out_dat), .out_flag(out_flag),
    .frame_err(frame_err), .parity_err(parity_err), .brk_det(brk_det), .rx_busy(rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc = cyc + 1;

  typedef struct {
    int            cyc;
    logic [DB-1:0] dat;
    logic          fe;
    logic          pe;
    logic          brk;
  } rec_t;
  rec_t flags[$];
  rec_t mon_r;
  int   busy_rises = 0, busy_rise_cyc = -1, busy_fall_cyc = -1;
  int   dbl_flags = 0, stray_brk = 0;
  logic prev_flag = 1'b0, prev_busy = 1'b0;

  always @(negedge sys_clk) begin
    if (out_flag) begin
      mon_r.cyc = cyc; mon_r.dat = out_dat; mon_r.fe = frame_err;
      mon_r.pe = parity_err; mon_r.brk = brk_det;
      flags.push_back(mon_r);
    end
    if (out_flag && prev_flag) dbl_flags++;
    if (brk_det && !out_flag) stray_brk++;
    if (rx_busy && !prev_busy) begin busy_rises++; busy_rise_cyc = cyc; end
    if (!rx_busy && prev_busy) busy_fall_cyc = cyc;
    prev_flag = out_flag;
    prev_busy = rx_busy;
  end

  int checks = 0, failures = 0;
  int last_flag_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  function automatic logic par_bit(input logic [DB-1:0] d, input logic flip);
    return (^d) ^ (PODD != 0) ^ flip;
  endfunction

  // e = first cycle the synchronised line shows the start bit (2 cycles after the drive)
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic flip,
                            output int e);
    e = cyc + 2;
    drive_bit(1'b0, C);
    for (int i = 0; i < DB; i++) drive_bit(d[i], C);
    if (P == 1) drive_bit(par_bit(d, flip), C);
    drive_bit(stop_v, C);
    for (int i = 1; i < SB; i++) drive_bit(1'b1, C);
    rxd = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [DB-1:0] d, input logic fe,
                              input logic pe, input logic brk, input int e);
    rec_t r;
    int   exp_cyc;
    exp_cyc = e + 1 + (NBITS - 1) * C + M + 2;
    chk({tag, "_nflag"}, flags.size(), 1);
    if (flags.size() > 0) begin
      r = flags.pop_front();
      last_flag_cyc = r.cyc;
      chk({tag, "_cyc"}, r.cyc, exp_cyc);
      chk({tag, "_dat"}, r.dat, d);
      chk({tag, "_fe"},  r.fe, fe);
      chk({tag, "_pe"},  r.pe, pe);
      chk({tag, "_brk"}, r.brk, brk);
    end
    flags.delete();
    chk({tag, "_held"}, out_dat, d);
  endtask

  initial begin
    int            e, rises;
    logic [DB-1:0] d;
    logic          sv, fl, pb;

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_outs", {out_dat, out_flag, frame_err, parity_err, brk_det, rx_busy}, 0);
    rst = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    chk("idle_busy", rx_busy, 0);

    send_frame(8'h55, 1'b1, 1'b0, e);
    expect_frame("f55", 8'h55, 1'b0, 1'b0, 1'b0, e);
`ifndef UART_RX_PARITY_EN
    chk("f55_lat", last_flag_cyc - e, 155);
`endif
    chk("f55_busy_rise", busy_rise_cyc, e + 1);
    chk("f55_busy_fall", busy_fall_cyc, last_flag_cyc);
    drive_bit(1'b1, C);
    chk("f55_busy_after", rx_busy, 0);

    e = cyc + 2;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 3 * C);
    chk("short_nflag", flags.size(), 0);
    chk("short_rise", busy_rise_cyc, e + 1);
    chk("short_busy_len", busy_fall_cyc - busy_rise_cyc, M + 2);

    send_frame(8'hA3, 1'b0, 1'b0, e);
    drive_bit(1'b1, 2 * C);
    expect_frame("fa3", 8'hA3, 1'b1, 1'b0, 1'b0, e);
    send_frame(8'h3C, 1'b1, 1'b0, e);
    drive_bit(1'b1, C);
    expect_frame("f3c", 8'h3C, 1'b0, 1'b0, 1'b0, e);

    e = cyc + 2;
    drive_bit(1'b0, 12 * C);
    drive_bit(1'b1, 3 * C);
    expect_frame("brk", '0, 1'b1, (P == 1) && (PODD != 0), (P == 0) || (PODD == 0), e);
    drive_bit(1'b1, 2 * C);
    chk("brk_no_second", flags.size(), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, e);
    drive_bit(1'b1, C);
    expect_frame("par_ok", 8'h07, 1'b0, 1'b0, 1'b0, e);
    send_frame(8'h07, 1'b1, 1'b1, e);
    drive_bit(1'b1, C);
    expect_frame("par_bad", 8'h07, 1'b0, 1'b1, 1'b0, e);
`endif

    for (int k = 0; k < 12; k++) begin
      d  = DB'($urandom_range(0, (1 << DB) - 1));
      sv = ($urandom_range(0, 5) != 0);
      fl = (P == 1) && ($urandom_range(0, 3) == 0);
      if (k == 5) begin d = '0; sv = 1'b0; end
      pb = par_bit(d, fl);
      send_frame(d, sv, fl, e);
      expect_frame("rnd", d, !sv, fl, (d == '0) && !sv && ((P == 0) || !pb), e);
      if (sv) drive_bit(1'b1, $urandom_range(0, C));
      else    drive_bit(1'b1, C + $urandom_range(0, C));
    end

    send_frame(8'hC5, 1'b1, 1'b0, e);
    drive_bit(1'b1, C);
    expect_frame("pre_rst", 8'hC5, 1'b0, 1'b0, 1'b0, e);
    d = 8'h81;
    drive_bit(1'b0, C);
    for (int i = 0; i < 4; i++) drive_bit(d[i], C);
    drive_bit(d[4], 5);
    rxd = 1'b0;
    rst = 1'b0;
    #2;
    chk("rst_mid_outs", {out_dat, out_flag, frame_err, parity_err, brk_det, rx_busy}, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    rises = busy_rises;
    rst = 1'b1;
    repeat (3 * C) @(posedge sys_clk);
    #1;
    chk("rst_low_no_start", busy_rises - rises, 0);
    chk("rst_no_flag", flags.size(), 0);
    drive_bit(1'b1, C);
    send_frame(8'h81, 1'b1, 1'b0, e);
    drive_bit(1'b1, C);
    expect_frame("f81", 8'h81, 1'b0, 1'b0, 1'b0, e);

    chk("no_double_flag", dbl_flags, 0);
    chk("no_stray_brk", stray_brk, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
